div_arbiter: RTL and testbench

Round-robin scheduler that shares one blocking `divider2` instance among up to `REQUESTERS` arithmetic clients, such as per-formant phi, bandwidth and gain engines. It accepts level requests with operands and grants one requester at a time. It drives the divider's operand and valid ports, counts the divider's fixed latency, and returns quotient and remainder tagged with the requester ID. The block removes the need for each engine to own a 64-bit divider.

---
 rtl/div_arb_pkg.sv | 20 ++
 rtl/div_arbiter_if.sv | 43 ++++
 rtl/div_arbiter_rr_picker.sv | 39 +++
 rtl/div_arbiter.sv | 159 +++++++++++++++
 tb/tb_div_arbiter.sv | 364 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/div_arb_pkg.sv
`default_nettype none
//==============================================================================
// div_arb_pkg : shared state encoding and sizing helpers for div_arbiter. Rev 1.0
//==============================================================================
package div_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        FINISH = 2'd2
    } state_t;

    localparam int c_DEFAULT_DIV_LATENCY = 66;

    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/div_arbiter_if.sv
`default_nettype none
//==============================================================================
// div_arbiter_if : client request/result bus plus divider-side port bundle. Rev 1.0
//==============================================================================
interface div_arbiter_if
    import div_arb_pkg::*;
#(
    parameter int WIDTH      = 64,
    parameter int REQUESTERS = 4
);
    localparam int ID_W = id_width(REQUESTERS);

    logic [REQUESTERS-1:0]       req_in;
    logic [REQUESTERS*WIDTH-1:0] dividend_in;
    logic [REQUESTERS*WIDTH-1:0] divisor_in;
    logic [REQUESTERS-1:0]       grant_out;
    logic                        result_valid_out;
    logic [ID_W-1:0]             result_id_out;
    logic [WIDTH-1:0]            quotient_out;
    logic [WIDTH-1:0]            remainder_out;
    logic                        div_zero_out;
    logic [WIDTH-1:0]            div_dividend_out;
    logic [WIDTH-1:0]            div_divisor_out;
    logic                        div_valid_out;
    logic [WIDTH-1:0]            div_quotient_in;
    logic [WIDTH-1:0]            div_remainder_in;

    // Arbiter side
    modport master (
        input  req_in, dividend_in, divisor_in, div_quotient_in, div_remainder_in,
        output grant_out, result_valid_out, result_id_out, quotient_out, remainder_out,
               div_zero_out, div_dividend_out, div_divisor_out, div_valid_out
    );

    // Clients and divider side
    modport slave (
        output req_in, dividend_in, divisor_in, div_quotient_in, div_remainder_in,
        input  grant_out, result_valid_out, result_id_out, quotient_out, remainder_out,
               div_zero_out, div_dividend_out, div_divisor_out, div_valid_out
    );

endinterface
`default_nettype wire

// File: rtl/div_arbiter_rr_picker.sv
`default_nettype none
//==============================================================================
// rr_picker : combinational round-robin pick, first request after the pointer. Rev 1.0
//==============================================================================
module rr_picker
    import div_arb_pkg::*;
#(
    parameter int REQUESTERS = 4,
    parameter int ID_W       = id_width(REQUESTERS)
) (
    input  logic [REQUESTERS-1:0] req_i,
    input  logic [ID_W-1:0]       ptr_i,
    output logic [REQUESTERS-1:0] grant_o,
    output logic [ID_W-1:0]       id_o
);

    int          idx;
    logic [ID_W-1:0] sel;
    logic        found;

    always_comb begin
        grant_o = '0;
        id_o    = '0;
        found   = 1'b0;
        idx     = 0;
        sel     = '0;
        for (int off = 1; off <= REQUESTERS; off++) begin
            idx = (int'(ptr_i) + off) % REQUESTERS;
            sel = ID_W'(idx);
            if (!found && req_i[sel]) begin
                found        = 1'b1;
                grant_o[sel] = 1'b1;
                id_o         = sel;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/div_arbiter.sv
`default_nettype none
//==============================================================================
// div_arbiter : round-robin sharing of one fixed-latency divider. Rev 1.0
// Define DIV_ARBITER_SIGNED_EN for two's-complement operands and results.
//==============================================================================
module div_arbiter
    import div_arb_pkg::*;
#(
    parameter int WIDTH       = 64,
    parameter int REQUESTERS  = 4,
    parameter int DIV_LATENCY = c_DEFAULT_DIV_LATENCY
) (
    input  logic          clk_in,
    input  logic          rst_in,
    div_arbiter_if.master bus
);

    localparam int ID_W  = id_width(REQUESTERS);
    localparam int CNT_W = $clog2(DIV_LATENCY) + 1;
    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(DIV_LATENCY - 1);

    state_t                state_q;
    logic [ID_W-1:0]       ptr_q, id_q, result_id_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [REQUESTERS-1:0] grant_q;
    logic                  div_valid_q, result_valid_q, div_zero_q;
    logic [WIDTH-1:0]      div_dividend_q, div_divisor_q, dividend_q;
    logic [WIDTH-1:0]      quotient_q, remainder_q;

    logic [REQUESTERS-1:0] pick_grant;
    logic [ID_W-1:0]       pick_id;
    logic [WIDTH-1:0]      sel_dividend_d, sel_divisor_d;
    logic [WIDTH-1:0]      mag_dividend_d, mag_divisor_d;
    logic [WIDTH-1:0]      quotient_d, remainder_d;

    rr_picker #(
        .REQUESTERS (REQUESTERS),
        .ID_W       (ID_W)
    ) u_picker (
        .req_i   (bus.req_in),
        .ptr_i   (ptr_q),
        .grant_o (pick_grant),
        .id_o    (pick_id)
    );

    always_comb begin
        sel_dividend_d = '0;
        sel_divisor_d  = '0;
        for (int i = 0; i < REQUESTERS; i++) begin
            if (pick_grant[i]) begin
                sel_dividend_d = bus.dividend_in[i*WIDTH +: WIDTH];
                sel_divisor_d  = bus.divisor_in[i*WIDTH +: WIDTH];
            end
        end
    end

`ifdef DIV_ARBITER_SIGNED_EN
    logic neg_dividend_q, neg_quot_q;

    // Negating the most negative value yields 2^(WIDTH-1), the correct magnitude.
    assign mag_dividend_d = sel_dividend_d[WIDTH-1] ? -sel_dividend_d : sel_dividend_d;
    assign mag_divisor_d  = sel_divisor_d[WIDTH-1]  ? -sel_divisor_d  : sel_divisor_d;
    assign quotient_d     = neg_quot_q     ? -bus.div_quotient_in  : bus.div_quotient_in;
    assign remainder_d    = neg_dividend_q ? -bus.div_remainder_in : bus.div_remainder_in;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            neg_dividend_q <= 1'b0;
            neg_quot_q     <= 1'b0;
        end else if (state_q == IDLE && |bus.req_in) begin
            neg_dividend_q <= sel_dividend_d[WIDTH-1];
            neg_quot_q     <= sel_dividend_d[WIDTH-1] ^ sel_divisor_d[WIDTH-1];
        end
    end
`else
    assign mag_dividend_d = sel_dividend_d;
    assign mag_divisor_d  = sel_divisor_d;
    assign quotient_d     = bus.div_quotient_in;
    assign remainder_d    = bus.div_remainder_in;
`endif

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q        <= IDLE;
            ptr_q          <= ID_W'(REQUESTERS - 1);
            id_q           <= '0;
            cnt_q          <= '0;
            grant_q        <= '0;
            div_valid_q    <= 1'b0;
            div_dividend_q <= '0;
            div_divisor_q  <= '0;
            dividend_q     <= '0;
            result_valid_q <= 1'b0;
            result_id_q    <= '0;
            quotient_q     <= '0;
            remainder_q    <= '0;
            div_zero_q     <= 1'b0;
        end else begin
            grant_q        <= '0;
            div_valid_q    <= 1'b0;
            result_valid_q <= 1'b0;
            div_zero_q     <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (|bus.req_in) begin
                        grant_q    <= pick_grant;
                        ptr_q      <= pick_id;
                        id_q       <= pick_id;
                        dividend_q <= sel_dividend_d;
                        if (sel_divisor_d != '0) begin
                            div_dividend_q <= mag_dividend_d;
                            div_divisor_q  <= mag_divisor_d;
                            div_valid_q    <= 1'b1;
                            cnt_q          <= '0;
                            state_q        <= WAIT;
                        end else begin
                            state_q <= FINISH;
                        end
                    end
                end
                WAIT: begin
                    // Counting starts once the divider has sampled the valid pulse.
                    if (!div_valid_q) begin
                        if (cnt_q == c_CNT_LAST) begin
                            quotient_q     <= quotient_d;
                            remainder_q    <= remainder_d;
                            result_id_q    <= id_q;
                            result_valid_q <= 1'b1;
                            state_q        <= IDLE;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                FINISH: begin
                    quotient_q     <= '1;
                    remainder_q    <= dividend_q;
                    result_id_q    <= id_q;
                    div_zero_q     <= 1'b1;
                    result_valid_q <= 1'b1;
                    state_q        <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.grant_out        = grant_q;
    assign bus.result_valid_out = result_valid_q;
    assign bus.result_id_out    = result_id_q;
    assign bus.quotient_out     = quotient_q;
    assign bus.remainder_out    = remainder_q;
    assign bus.div_zero_out     = div_zero_q;
    assign bus.div_dividend_out = div_dividend_q;
    assign bus.div_divisor_out  = div_divisor_q;
    assign bus.div_valid_out    = div_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_div_arbiter.sv
`default_nettype none
//==============================================================================
// tb_div_arbiter : directed self-checking bench with a fixed-latency divider model. Rev 1.0
//==============================================================================
module tb_div_arbiter;
    import div_arb_pkg::*;

    localparam int W = 64;
    localparam int R = 4;
    localparam int L = 66;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    div_arbiter_if #(.WIDTH(W), .REQUESTERS(R)) bus ();

    div_arbiter #(
        .WIDTH       (W),
        .REQUESTERS  (R),
        .DIV_LATENCY (L)
    ) dut (
        .clk_in (clk),
        .rst_in (rst),
        .bus    (bus)
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Divider model: garbage until L cycles after it samples valid.
    logic [W-1:0] ma = '0;
    logic [W-1:0] mb = '0;
    int           mcnt = 1000;
    always @(posedge clk) begin
        if (bus.div_valid_out) begin
            ma   <= bus.div_dividend_out;
            mb   <= bus.div_divisor_out;
            mcnt <= 1;
        end else if (mcnt < 1000) begin
            mcnt <= mcnt + 1;
        end
    end
    assign bus.div_quotient_in  = (mcnt >= L && mb != 0) ? ma / mb : 64'hBADB_ADBA_DBAD_BAD0;
    assign bus.div_remainder_in = (mcnt >= L && mb != 0) ? ma % mb : 64'hBADB_ADBA_DBAD_BAD1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic set_op(input int c, input logic [W-1:0] a, input logic [W-1:0] b);
        bus.dividend_in[c*W +: W] = a;
        bus.divisor_in[c*W +: W]  = b;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.req_in = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_grant(input int maxc, output int at, output logic [R-1:0] g, output bit ok);
        ok = 1'b0; at = 0; g = '0;
        for (int i = 0; i < maxc; i++) begin
            @(negedge clk);
            if (bus.grant_out != '0) begin
                ok = 1'b1; at = cyc; g = bus.grant_out;
                break;
            end
        end
    endtask

    task automatic wait_result(input int maxc, output int at, output bit ok);
        ok = 1'b0; at = 0;
        for (int i = 0; i < maxc; i++) begin
            @(negedge clk);
            if (bus.result_valid_out) begin
                ok = 1'b1; at = cyc;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.grant_out, bus.result_valid_out, bus.div_zero_out, bus.div_valid_out, bus.result_id_out} !== '0) begin
            errors++;
            $display("FAIL reset_ctrl: got grant=%b rv=%b dz=%b dv=%b id=%0d, required all 0",
                     bus.grant_out, bus.result_valid_out, bus.div_zero_out, bus.div_valid_out, bus.result_id_out);
        end
        checks++;
        if ({bus.quotient_out, bus.remainder_out, bus.div_dividend_out, bus.div_divisor_out} !== '0) begin
            errors++;
            $display("FAIL reset_data: got q=%h r=%h dd=%h ds=%h, required all 0",
                     bus.quotient_out, bus.remainder_out, bus.div_dividend_out, bus.div_divisor_out);
        end
        rst = 1'b0;
    endtask

    task automatic test_single();
        int at, rat, req_cyc; logic [R-1:0] g; bit ok;
        apply_reset();
        set_op(1, 64'd100, 64'd7);
        bus.req_in = 4'b0010;
        req_cyc = cyc;
        wait_grant(10, at, g, ok);
        bus.req_in[1] = 1'b0;
        checks++;
        if (!ok || g !== 4'b0010 || at != req_cyc + 1) begin
            errors++;
            $display("FAIL single_grant: got %b at cycle %0d, required 0010 at cycle %0d", g, at, req_cyc + 1);
        end
        checks++;
        if (bus.div_valid_out !== 1'b1 || bus.div_dividend_out !== 64'd100 || bus.div_divisor_out !== 64'd7) begin
            errors++;
            $display("FAIL single_div_drive: got dv=%b dd=%0d ds=%0d, required 1/100/7",
                     bus.div_valid_out, bus.div_dividend_out, bus.div_divisor_out);
        end
        wait_result(200, rat, ok);
        checks++;
        if (!ok || rat != at + L + 1) begin
            errors++;
            $display("FAIL single_latency: got result at %0d, required %0d", rat, at + L + 1);
        end
        checks++;
        if (bus.quotient_out !== 64'd14 || bus.remainder_out !== 64'd2) begin
            errors++;
            $display("FAIL single_value: got q=%0d r=%0d, required q=14 r=2", bus.quotient_out, bus.remainder_out);
        end
        checks++;
        if (bus.result_id_out !== 2'd1 || bus.div_zero_out !== 1'b0) begin
            errors++;
            $display("FAIL single_id: got id=%0d dz=%b, required id=1 dz=0", bus.result_id_out, bus.div_zero_out);
        end
        @(negedge clk);
        checks++;
        if (bus.result_valid_out !== 1'b0 || bus.quotient_out !== 64'd14) begin
            errors++;
            $display("FAIL single_hold: got rv=%b q=%0d, required rv=0 q=14", bus.result_valid_out, bus.quotient_out);
        end
    endtask

    task automatic test_all_four();
        int at, prev, rat; logic [R-1:0] g; bit ok;
        int qexp [4] = '{3, 6, 10, 13};
        int rexp [4] = '{1, 2, 0, 1};
        apply_reset();
        for (int c = 0; c < R; c++) set_op(c, W'(10 * (c + 1)), 64'd3);
        bus.req_in = 4'b1111;
        prev = 0;
        for (int k = 0; k < R; k++) begin
            wait_grant(200, at, g, ok);
            bus.req_in[k] = 1'b0;
            checks++;
            if (!ok || g !== R'(1 << k)) begin
                errors++;
                $display("FAIL all4_grant%0d: got %b, required %b", k, g, R'(1 << k));
            end
            if (k > 0) begin
                checks++;
                if (at - prev != L + 2) begin
                    errors++;
                    $display("FAIL all4_spacing%0d: got %0d cycles, required %0d", k, at - prev, L + 2);
                end
            end
            prev = at;
            wait_result(200, rat, ok);
            checks++;
            if (!ok || bus.quotient_out !== W'(qexp[k]) || bus.remainder_out !== W'(rexp[k]) ||
                bus.result_id_out !== 2'(k)) begin
                errors++;
                $display("FAIL all4_result%0d: got q=%0d r=%0d id=%0d, required q=%0d r=%0d id=%0d",
                         k, bus.quotient_out, bus.remainder_out, bus.result_id_out, qexp[k], rexp[k], k);
            end
        end
    endtask

    task automatic test_fairness();
        int at, c; logic [R-1:0] g; bit ok;
        int seq [7] = '{0, 2, 0, 2, 0, 2, 3};
        apply_reset();
        set_op(0, 64'd50, 64'd5);
        set_op(2, 64'd60, 64'd5);
        set_op(3, 64'd70, 64'd5);
        bus.req_in = 4'b0101;
        for (int k = 0; k < 7; k++) begin
            wait_grant(200, at, g, ok);
            c = seq[k];
            checks++;
            if (!ok || g !== R'(1 << c)) begin
                errors++;
                $display("FAIL fair_grant%0d: got %b, required %b", k, g, R'(1 << c));
                break;
            end
            bus.req_in[c] = 1'b0;
            if (k == 4) bus.req_in[3] = 1'b1;
            @(negedge clk);
            if (k < 6 && c != 3) bus.req_in[c] = 1'b1;
        end
        bus.req_in = '0;
    endtask

    task automatic test_zero_div();
        int at, rat, dv_seen; logic [R-1:0] g; bit ok;
        apply_reset();
        set_op(2, 64'd55, 64'd0);
        bus.req_in = 4'b0100;
        dv_seen = 0;
        wait_grant(10, at, g, ok);
        bus.req_in[2] = 1'b0;
        if (bus.div_valid_out) dv_seen++;
        checks++;
        if (!ok || g !== 4'b0100) begin
            errors++;
            $display("FAIL zero_grant: got %b, required 0100", g);
        end
        wait_result(5, rat, ok);
        if (bus.div_valid_out) dv_seen++;
        checks++;
        if (!ok || rat != at + 1) begin
            errors++;
            $display("FAIL zero_latency: got result at %0d, required %0d", rat, at + 1);
        end
        checks++;
        if (bus.quotient_out !== '1 || bus.remainder_out !== 64'd55 || bus.div_zero_out !== 1'b1 ||
            bus.result_id_out !== 2'd2) begin
            errors++;
            $display("FAIL zero_result: got q=%h r=%0d dz=%b id=%0d, required q=all-ones r=55 dz=1 id=2",
                     bus.quotient_out, bus.remainder_out, bus.div_zero_out, bus.result_id_out);
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (bus.div_valid_out) dv_seen++;
        end
        checks++;
        if (dv_seen != 0 || bus.div_zero_out !== 1'b0) begin
            errors++;
            $display("FAIL zero_no_divvalid: got %0d div_valid pulses dz=%b, required 0 and dz=0",
                     dv_seen, bus.div_zero_out);
        end
    endtask

`ifdef DIV_ARBITER_SIGNED_EN
    task automatic test_signed();
        int at, rat; logic [R-1:0] g; bit ok;
        logic [W-1:0] a [2] = '{-64'sd100, 64'sd100};
        logic [W-1:0] b [2] = '{64'sd7, -64'sd7};
        logic [W-1:0] q [2] = '{-64'sd14, -64'sd14};
        logic [W-1:0] r [2] = '{-64'sd2, 64'sd2};
        for (int k = 0; k < 2; k++) begin
            apply_reset();
            set_op(0, a[k], b[k]);
            bus.req_in = 4'b0001;
            wait_grant(10, at, g, ok);
            bus.req_in = '0;
            checks++;
            if (!ok || bus.div_dividend_out !== 64'd100 || bus.div_divisor_out !== 64'd7) begin
                errors++;
                $display("FAIL signed_mag%0d: got dd=%0d ds=%0d, required 100/7",
                         k, bus.div_dividend_out, bus.div_divisor_out);
            end
            wait_result(200, rat, ok);
            checks++;
            if (!ok || bus.quotient_out !== q[k] || bus.remainder_out !== r[k]) begin
                errors++;
                $display("FAIL signed_result%0d: got q=%h r=%h, required q=%h r=%h",
                         k, bus.quotient_out, bus.remainder_out, q[k], r[k]);
            end
        end
    endtask
`else
    task automatic test_unsigned();
        int at, rat; logic [R-1:0] g; bit ok;
        apply_reset();
        set_op(0, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7);
        bus.req_in = 4'b0001;
        wait_grant(10, at, g, ok);
        bus.req_in = '0;
        checks++;
        if (!ok || bus.div_dividend_out !== 64'hFFFF_FFFF_FFFF_FF9C) begin
            errors++;
            $display("FAIL unsigned_pass: got dd=%h, required FFFFFFFFFFFFFF9C", bus.div_dividend_out);
        end
        wait_result(200, rat, ok);
        checks++;
        if (!ok || bus.quotient_out !== 64'd2635249153387078788 || bus.remainder_out !== 64'd0) begin
            errors++;
            $display("FAIL unsigned_result: got q=%0d r=%0d, required q=2635249153387078788 r=0",
                     bus.quotient_out, bus.remainder_out);
        end
    endtask
`endif

    task automatic test_reset_in_wait();
        int at, rv_seen; logic [R-1:0] g; bit ok;
        apply_reset();
        set_op(1, 64'd100, 64'd7);
        bus.req_in = 4'b0010;
        wait_grant(10, at, g, ok);
        bus.req_in = '0;
        while (cyc < at + 30) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus.grant_out, bus.result_valid_out, bus.div_zero_out, bus.div_valid_out, bus.result_id_out,
             bus.quotient_out, bus.remainder_out, bus.div_dividend_out, bus.div_divisor_out} !== '0) begin
            errors++;
            $display("FAIL rstwait_outputs: got grant=%b rv=%b dv=%b q=%h dd=%h, required all 0",
                     bus.grant_out, bus.result_valid_out, bus.div_valid_out, bus.quotient_out, bus.div_dividend_out);
        end
        rv_seen = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (bus.result_valid_out) rv_seen++;
        end
        checks++;
        if (rv_seen != 0) begin
            errors++;
            $display("FAIL rstwait_no_result: got %0d result pulses, required 0", rv_seen);
        end
        set_op(0, 64'd9, 64'd3);
        set_op(2, 64'd8, 64'd2);
        bus.req_in = 4'b0101;
        wait_grant(10, at, g, ok);
        bus.req_in = '0;
        checks++;
        if (!ok || g !== 4'b0001) begin
            errors++;
            $display("FAIL rstwait_first_grant: got %b, required 0001", g);
        end
    endtask

    initial begin
        bus.req_in      = '0;
        bus.dividend_in = '0;
        bus.divisor_in  = '0;
        test_reset();
        test_single();
        test_all_four();
        test_fairness();
        test_zero_div();
`ifdef DIV_ARBITER_SIGNED_EN
        test_signed();
`else
        test_unsigned();
`endif
        test_reset_in_wait();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
